// File: rtl/pwm_modport_if.sv
// PWM control/observation bundle: the driver programs duty, period and enable,
// the PWM block consumes them and the monitor watches the waveform and period strobe.
interface pwm_intf #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pwm_value;
    logic [WIDTH-1:0] pwm_range;
    logic             pwm_en;
    logic             pwm_period;
    logic             pwm_out;

    modport master (
        output pwm_value,
        output pwm_range,
        output pwm_en,
        input  pwm_period,
        input  pwm_out
    );

    modport slave (
        input  pwm_value,
        input  pwm_range,
        input  pwm_en,
        output pwm_period,
        output pwm_out
    );

    modport monitor (
        input pwm_value,
        input pwm_range,
        input pwm_en,
        input pwm_period,
        input pwm_out
    );
endinterface

// File: rtl/pwm_modport.sv
// Single-channel PWM generator with registered waveform and end-of-period strobe.
// Define PWM_SYNC_LOAD_EN to load duty/period shadows only at period wrap while running.
module pwm_modport #(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    pwm_intf.slave  bus
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_value_q;
    logic [WIDTH-1:0] r_range_q;
    logic             r_out;
    logic             r_period;
    logic             w_wrap;

    // Wrap is tested before the increment, so a full-range period never overflows.
    assign w_wrap = (r_cnt == r_range_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_value_q <= '0;
            r_range_q <= '0;
            r_out     <= 1'b0;
            r_period  <= 1'b0;
        end else if (!bus.pwm_en) begin
            r_cnt     <= '0;
            r_out     <= 1'b0;
            r_period  <= 1'b0;
            r_value_q <= bus.pwm_value;
            r_range_q <= bus.pwm_range;
        end else begin
            r_cnt    <= w_wrap ? '0 : r_cnt + WIDTH'(1);
            r_out    <= (r_cnt < r_value_q);
            r_period <= w_wrap;
`ifdef PWM_SYNC_LOAD_EN
            if (w_wrap) begin
                r_value_q <= bus.pwm_value;
                r_range_q <= bus.pwm_range;
            end
`else
            r_value_q <= bus.pwm_value;
            r_range_q <= bus.pwm_range;
`endif
        end
    end

    assign bus.pwm_out    = r_out;
    assign bus.pwm_period = r_period;
endmodule

// File: tb/tb_pwm_modport.sv
// Directed bench for pwm_modport: steady-state vector table plus hand-written
// reset, enable-drop and mid-period reprogramming sequences.
module tb_pwm_modport;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] value;
        logic [W-1:0] range;
        int           cycles;
        int           exp_high;
        int           exp_pulses;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    vec_t vecs[6];

    pwm_intf #(.WIDTH(W)) u_if ();

    pwm_modport #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load shadows while idle, then run enabled and compare each cycle to the
    // period/duty rule: at enabled edge k the counter used is (k-1) mod (range+1).
    task automatic run_vec(input string name, input vec_t v);
        int mism, highs, pulses, p, c;
        bit eo, ep;
        mism = 0; highs = 0; pulses = 0;
        u_if.pwm_en    = 1'b0;
        u_if.pwm_value = v.value;
        u_if.pwm_range = v.range;
        step();
        step();
        check({name, "_idle_out"}, int'(u_if.pwm_out), 0);
        u_if.pwm_en = 1'b1;
        p = int'(v.range) + 1;
        for (int k = 1; k <= v.cycles; k++) begin
            step();
            c  = (k - 1) % p;
            eo = (c < int'(v.value));
            ep = (c == int'(v.range));
            if (u_if.pwm_out !== eo || u_if.pwm_period !== ep) mism++;
            if (u_if.pwm_out === 1'b1) highs++;
            if (u_if.pwm_period === 1'b1) pulses++;
        end
        check({name, "_wave_mismatches"}, mism, 0);
        check({name, "_high_cycles"}, highs, v.exp_high);
        check({name, "_period_pulses"}, pulses, v.exp_pulses);
    endtask

    initial begin
        int  exp_v, c;
        bit  eo;
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{value: 8'd3,   range: 8'd9,   cycles: 50,  exp_high: 15,  exp_pulses: 5};
        vecs[1] = '{value: 8'd0,   range: 8'd5,   cycles: 36,  exp_high: 0,   exp_pulses: 6};
        vecs[2] = '{value: 8'd8,   range: 8'd5,   cycles: 36,  exp_high: 36,  exp_pulses: 6};
        vecs[3] = '{value: 8'd1,   range: 8'd0,   cycles: 10,  exp_high: 10,  exp_pulses: 10};
        vecs[4] = '{value: 8'd6,   range: 8'd6,   cycles: 21,  exp_high: 18,  exp_pulses: 3};
        vecs[5] = '{value: 8'd255, range: 8'd255, cycles: 512, exp_high: 510, exp_pulses: 2};

        // Reset asserted with enable high: outputs clear before any clock edge.
        reset          = 1'b1;
        u_if.pwm_en    = 1'b1;
        u_if.pwm_value = 8'd3;
        u_if.pwm_range = 8'd9;
        #1 reset = 1'b0;
        #1;
        check("reset_async_out", int'(u_if.pwm_out), 0);
        check("reset_async_period", int'(u_if.pwm_period), 0);
        step();
        step();
        check("reset_held_out", int'(u_if.pwm_out), 0);
        reset = 1'b1;
        // Shadows are zero after reset, so the first edge is a 1-cycle wrap.
        step();
        check("first_edge_out", int'(u_if.pwm_out), 0);
        check("first_edge_period", int'(u_if.pwm_period), 1);
        step();
        check("second_edge_out", int'(u_if.pwm_out), 1);
        check("second_edge_period", int'(u_if.pwm_period), 0);
        step();
        step();
        check("fourth_edge_out", int'(u_if.pwm_out), 1);
        step();
        check("fifth_edge_out", int'(u_if.pwm_out), 0);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Enable dropped while the output is high.
        u_if.pwm_en = 1'b0; u_if.pwm_value = 8'd3; u_if.pwm_range = 8'd9;
        step();
        u_if.pwm_en = 1'b1;
        step();
        step();
        check("pre_drop_out", int'(u_if.pwm_out), 1);
        u_if.pwm_en = 1'b0;
        step();
        check("drop_mid_out", int'(u_if.pwm_out), 0);
        check("drop_mid_period", int'(u_if.pwm_period), 0);

        // Enable dropped on the wrap cycle: idle wins, no strobe.
        u_if.pwm_en = 1'b1;
        for (int k = 0; k < 9; k++) step();
        u_if.pwm_en = 1'b0;
        step();
        check("drop_wrap_period", int'(u_if.pwm_period), 0);
        check("drop_wrap_out", int'(u_if.pwm_out), 0);

        run_vec("reenable", '{value: 8'd2, range: 8'd4, cycles: 10, exp_high: 4, exp_pulses: 2});

        // Duty changed after the 4th edge of a period (counter at 4).
        u_if.pwm_en = 1'b0; u_if.pwm_value = 8'd3; u_if.pwm_range = 8'd9;
        step();
        u_if.pwm_en = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        u_if.pwm_value = 8'd7;
        begin
            int mism, highs2;
            mism = 0; highs2 = 0;
            for (int k = 5; k <= 20; k++) begin
                step();
                c = (k - 1) % 10;
`ifdef PWM_SYNC_LOAD_EN
                exp_v = (k <= 10) ? 3 : 7;
`else
                exp_v = (k <= 5) ? 3 : 7;
`endif
                eo = (c < exp_v);
                if (u_if.pwm_out !== eo) mism++;
                if (k > 10 && u_if.pwm_out === 1'b1) highs2++;
            end
            check("duty_change_mismatches", mism, 0);
            check("duty_change_next_high", highs2, 7);
        end

        // Reset mid-period while the output is high.
        step();
        check("pre_reset_out", int'(u_if.pwm_out), 1);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_out", int'(u_if.pwm_out), 0);
        check("midrun_reset_period", int'(u_if.pwm_period), 0);
        step();
        reset = 1'b1;
        step();
        check("post_reset_edge1_period", int'(u_if.pwm_period), 1);
        check("post_reset_edge1_out", int'(u_if.pwm_out), 0);
        step();
        check("post_reset_edge2_out", int'(u_if.pwm_out), 1);
        check("post_reset_edge2_period", int'(u_if.pwm_period), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
